mmv_ram_responder: RTL and testbench

- Behavioural memory-mapped RAM responder: the slave end of the addr/wreq/wdat/rreq/rdat/rval/busy interface driven by the team's RAM testers.
- Stores 2^AWIDTH words of DWIDTH bits.
- Returns read data after a fixed pipeline latency.
- Can inject pseudo-random backpressure.
- Counts accepted transactions.
- Used in simulation benches and on-chip self-test loopbacks to exercise RAM testers without real memory.

---
 rtl/mmv_ram_responder.sv | 98 +++++++++
 tb/tb_mmv_ram_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmv_ram_responder.sv
// rtl/mmv_ram_responder.sv - behavioural RAM responder with read latency, random backpressure and counters
// Optional stuck-at-0 address fault: MMV_RAM_RESPONDER_FAULT_EN
module mmv_ram_responder #(
  parameter int AWIDTH    = 8,
  parameter int DWIDTH    = 8,
  parameter int RDLATENCY = 2,
  parameter int CWIDTH    = 16,
  localparam int FBW      = (AWIDTH > 1) ? $clog2(AWIDTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] s_addr,
  input  logic              s_wreq,
  input  logic [DWIDTH-1:0] s_wdat,
  input  logic              s_rreq,
  output logic [DWIDTH-1:0] s_rdat,
  output logic              s_rval,
  output logic              s_busy,
  input  logic              busy_ena,
  input  logic              fault_ena,
  input  logic [FBW-1:0]    fault_bit,
  output logic [CWIDTH-1:0] wr_cnt,
  output logic [CWIDTH-1:0] rd_cnt,
  output logic              collision
);

  logic [DWIDTH-1:0]    mem [0:(1<<AWIDTH)-1];
  logic [AWIDTH-1:0]    eff_addr;
  logic                 accept_w;
  logic                 accept_r;
  logic [15:0]          lfsr;
  logic                 lfsr_fb;
  logic [RDLATENCY-1:0] pipe_v;
  logic [DWIDTH-1:0]    pipe_d [RDLATENCY];

`ifdef MMV_RAM_RESPONDER_FAULT_EN
  always_comb begin
    eff_addr = s_addr;
    if (fault_ena && (int'(fault_bit) < AWIDTH))
      eff_addr[fault_bit] = 1'b0;
  end
`else
  logic unused_fault;
  assign unused_fault = fault_ena ^ (^fault_bit);
  assign eff_addr     = s_addr;
`endif

  // A simultaneous write wins; the read is dropped and reported via collision.
  assign accept_w = s_wreq & ~s_busy;
  assign accept_r = s_rreq & ~s_busy & ~s_wreq;
  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Memory has no reset so its contents survive a reset.
  always_ff @(posedge clk) begin
    if (accept_w && !reset)
      mem[eff_addr] <= s_wdat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr      <= 16'hACE1;
      s_busy    <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      collision <= 1'b0;
    end else begin
      lfsr      <= {lfsr[14:0], lfsr_fb};
      s_busy    <= busy_ena & lfsr[1] & lfsr[0];
      collision <= s_wreq & s_rreq & ~s_busy;
      if (accept_w)
        wr_cnt <= wr_cnt + CWIDTH'(1);
      if (accept_r)
        rd_cnt <= rd_cnt + CWIDTH'(1);
    end
  end

  // Last stage doubles as the output register, so data only loads with a valid beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_v <= '0;
      for (int i = 0; i < RDLATENCY; i++)
        pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= accept_r;
      if (accept_r)
        pipe_d[0] <= mem[eff_addr];
      for (int i = 1; i < RDLATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1])
          pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign s_rval = pipe_v[RDLATENCY-1];
  assign s_rdat = pipe_d[RDLATENCY-1];

endmodule

// File: tb/tb_mmv_ram_responder.sv
// tb/tb_mmv_ram_responder.sv - randomized bench for mmv_ram_responder against a cycle-level model
// Fault checks compile in with MMV_RAM_RESPONDER_FAULT_EN
module tb_mmv_ram_responder;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int L  = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] s_addr = '0;
  logic          s_wreq = 1'b0;
  logic [DW-1:0] s_wdat = '0;
  logic          s_rreq = 1'b0;
  logic [DW-1:0] s_rdat;
  logic          s_rval;
  logic          s_busy;
  logic          busy_ena = 1'b0;
  logic          fault_ena = 1'b0;
  logic [2:0]    fault_bit = '0;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic          collision;

  always #5 clk = ~clk;

  mmv_ram_responder #(.AWIDTH(AW), .DWIDTH(DW), .RDLATENCY(L), .CWIDTH(CW)) dut (
    .clk(clk), .reset(reset), .s_addr(s_addr), .s_wreq(s_wreq), .s_wdat(s_wdat),
    .s_rreq(s_rreq), .s_rdat(s_rdat), .s_rval(s_rval), .s_busy(s_busy),
    .busy_ena(busy_ena), .fault_ena(fault_ena), .fault_bit(fault_bit),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .collision(collision)
  );

  typedef struct {
    int       due;
    logic [7:0] d;
  } rd_t;

  logic [7:0]  m_mem [256];
  bit          m_busy;
  logic [15:0] m_lfsr;
  int          m_wr;
  int          m_rd;
  bit          m_coll;
  logic [7:0]  m_rdat;
  rd_t         pend[$];
  logic [7:0]  rlog[$];
  int          cyc = 0;
  int          nvec = 0;
  int          nerr = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, want);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_lfsr = 16'hACE1;
    m_wr   = 0;
    m_rd   = 0;
    m_coll = 0;
    m_rdat = '0;
    pend.delete();
  endtask

  function automatic logic [7:0] eff(input logic [7:0] a);
`ifdef MMV_RAM_RESPONDER_FAULT_EN
    if (fault_ena && fault_bit < AW)
      return a & ~(8'd1 << fault_bit);
`endif
    return a;
  endfunction

  // One clock: check outputs on the falling edge, then drive inputs and advance the model.
  task automatic step(input bit w, input bit r, input logic [7:0] a, input logic [7:0] d,
                      input bit be, input bit rst);
    bit exp_rval;
    bit acc_w;
    bit acc_r;
    @(negedge clk);
    exp_rval = (pend.size() > 0) && (pend[0].due == cyc);
    if (exp_rval) begin
      m_rdat = pend[0].d;
      void'(pend.pop_front());
    end
    cmp("s_busy", 64'(s_busy), 64'(m_busy));
    cmp("s_rval", 64'(s_rval), 64'(exp_rval));
    cmp("s_rdat", 64'(s_rdat), 64'(m_rdat));
    cmp("wr_cnt", 64'(wr_cnt), 64'(m_wr));
    cmp("rd_cnt", 64'(rd_cnt), 64'(m_rd));
    cmp("collision", 64'(collision), 64'(m_coll));
    if (s_rval)
      rlog.push_back(s_rdat);

    reset    = rst;
    s_wreq   = w;
    s_rreq   = r;
    s_addr   = a;
    s_wdat   = d;
    busy_ena = be;
    if (rst) begin
      model_reset();
    end else begin
      acc_w  = w && !m_busy;
      acc_r  = r && !m_busy && !w;
      m_coll = w && r && !m_busy;
      if (acc_r) begin
        pend.push_back('{due: cyc + L, d: m_mem[eff(a)]});
        m_rd = (m_rd + 1) % (1 << CW);
      end
      if (acc_w) begin
        m_mem[eff(a)] = d;
        m_wr = (m_wr + 1) % (1 << CW);
      end
      m_busy = be && m_lfsr[1] && m_lfsr[0];
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 8'h00, 8'h00, 0, 0);
  endtask

  function automatic logic [63:0] rlog_at(input int k);
    return (rlog.size() > k) ? 64'(rlog[k]) : 64'hDEAD;
  endfunction

  initial begin
    model_reset();

    // Backpressure from seed ACE1: clear after the first edge, busy after the second.
    step(0, 0, 8'h00, 8'h00, 1, 0);
    step(0, 0, 8'h00, 8'h00, 1, 0);
    cmp("lfsr_first_idle", 64'(s_busy), 64'd0);
    step(0, 0, 8'h00, 8'h00, 1, 0);
    cmp("lfsr_first_busy", 64'(s_busy), 64'd1);
    step(0, 0, 8'h00, 8'h00, 0, 1);
    idle(1);
    cmp("reset_rdat", 64'(s_rdat), 64'd0);

    // Basic write then read
    rlog.delete();
    step(1, 0, 8'h01, 8'h55, 0, 0);
    step(0, 1, 8'h01, 8'h00, 0, 0);
    idle(2);
    cmp("basic_count", 64'(rlog.size()), 64'd1);
    cmp("basic_data", rlog_at(0), 64'h55);
    cmp("basic_wr_cnt", 64'(wr_cnt), 64'd1);
    cmp("basic_rd_cnt", 64'(rd_cnt), 64'd1);

    // Back-to-back reads
    for (int k = 0; k < 4; k++)
      step(1, 0, 8'(k), 8'(8'h10 + k), 0, 0);
    rlog.delete();
    for (int k = 0; k < 4; k++)
      step(0, 1, 8'(k), 8'h00, 0, 0);
    idle(2);
    cmp("b2b_count", 64'(rlog.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      cmp("b2b_data", rlog_at(k), 64'(8'h10 + k));

    // Collision: write wins, read dropped
    rlog.delete();
    step(1, 1, 8'h05, 8'hA5, 0, 0);
    idle(1);
    cmp("coll_pulse", 64'(collision), 64'd1);
    cmp("coll_rd_cnt", 64'(rd_cnt), 64'd5);
    cmp("coll_wr_cnt", 64'(wr_cnt), 64'd6);
    idle(1);
    cmp("coll_once", 64'(collision), 64'd0);
    step(0, 1, 8'h05, 8'h00, 0, 0);
    idle(2);
    cmp("coll_rval_count", 64'(rlog.size()), 64'd1);
    cmp("coll_mem", rlog_at(0), 64'hA5);

    // Reset while a read is in flight
    rlog.delete();
    step(0, 1, 8'h01, 8'h00, 0, 0);
    step(0, 0, 8'h00, 8'h00, 0, 1);
    idle(3);
    cmp("rst_no_rval", 64'(rlog.size()), 64'd0);
    cmp("rst_rd_cnt", 64'(rd_cnt), 64'd0);
    cmp("rst_wr_cnt", 64'(wr_cnt), 64'd0);
    step(0, 1, 8'h01, 8'h00, 0, 0);
    idle(2);
    cmp("rst_mem_kept", rlog_at(0), 64'h11);

`ifdef MMV_RAM_RESPONDER_FAULT_EN
    rlog.delete();
    fault_ena = 1'b1;
    fault_bit = 3'd7;
    step(1, 0, 8'h80, 8'hAA, 0, 0);
    step(1, 0, 8'h00, 8'h55, 0, 0);
    step(0, 1, 8'h80, 8'h00, 0, 0);
    idle(2);
    cmp("fault_alias", rlog_at(0), 64'h55);
    fault_ena = 1'b0;
`endif

    // Fill memory so random reads never touch unwritten words
    for (int a = 0; a < 256; a++)
      step(1, 0, 8'(a), 8'($urandom), 0, 0);

    begin
      bit be = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 63) == 0)
          be = !be;
        step(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
             8'($urandom), 8'($urandom), be, ($urandom_range(0, 699) == 0));
      end
    end
    idle(L + 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
